// File: rtl/urv_dbg_mbx_host.sv
// rtl/urv_dbg_mbx_host.sv - host-side debug mailbox bridge with core->host response FIFO
//
// Purpose: forwards one host word at a time into the core's inbound mailbox,
// then waits for the core's outbound word. Outbound words are captured into a
// small FIFO at any time, including unsolicited ones arriving while idle.
// Optional feature: define URV_DBG_MBX_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles and raise the sticky h_err_timeout_o flag.
//
// Ports:
//   clk_i, rst_n_i                        clock, asynchronous active-low reset
//   h_wr_data_i/h_wr_valid_i/h_wr_ready_o host word towards the core
//   h_rd_data_o/h_rd_valid_o/h_rd_ready_i FIFO head towards the host
//   h_busy_o                              transaction in progress
//   h_err_timeout_o, h_err_clr_i          sticky timeout flag and its clear
//   dbg_mbxi_data_o/dbg_mbxi_valid_o      inbound mailbox word and load strobe
//   dbg_mbxo_data_i/dbg_mbxo_valid_i      outbound mailbox word and pending flag
//   dbg_mbxo_read_o                       outbound consume strobe
module urv_dbg_mbx_host #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int RD_FIFO_LOG2   = 2
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] h_wr_data_i,
   input  logic        h_wr_valid_i,
   output logic        h_wr_ready_o,
   output logic [31:0] h_rd_data_o,
   output logic        h_rd_valid_o,
   input  logic        h_rd_ready_i,
   output logic        h_busy_o,
   output logic        h_err_timeout_o,
   input  logic        h_err_clr_i,
   output logic [31:0] dbg_mbxi_data_o,
   output logic        dbg_mbxi_valid_o,
   input  logic [31:0] dbg_mbxo_data_i,
   input  logic        dbg_mbxo_valid_i,
   output logic        dbg_mbxo_read_o
);

   localparam int DEPTH = 1 << RD_FIFO_LOG2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nx;
   logic [31:0]             fifo_mem [DEPTH];
   logic [RD_FIFO_LOG2-1:0] wr_ptr;
   logic [RD_FIFO_LOG2-1:0] rd_ptr;
   logic [RD_FIFO_LOG2:0]   count;
   logic                    holdoff;
   logic                    empty;
   logic                    full;
   logic                    push;
   logic                    pop;
   logic                    accept;
   logic [31:0]             mbxi_data;

   assign empty = (count == '0);
   // count never exceeds DEPTH, so its top bit alone marks the full condition
   assign full  = count[RD_FIFO_LOG2];
   assign pop   = ~empty & h_rd_ready_i;

   // The core clears its valid one cycle after our strobe, so the cycle that
   // follows a strobe must not sample dbg_mbxo_valid_i again. holdoff also
   // resets high, which keeps the strobe quiet during and right after reset.
   // A full FIFO still accepts when the head is being popped in the same cycle.
   assign push            = dbg_mbxo_valid_i & ~holdoff & (~full | pop);
   assign dbg_mbxo_read_o = push;

   assign accept           = h_wr_valid_i & (state == IDLE);
   // Gated by reset so every output reads 0 while reset is held
   assign h_wr_ready_o     = (state == IDLE) & rst_n_i;
   assign h_busy_o         = (state != IDLE);
   assign dbg_mbxi_valid_o = (state == SEND);
   assign dbg_mbxi_data_o  = mbxi_data;
   assign h_rd_valid_o     = ~empty;
   assign h_rd_data_o      = empty ? 32'h0 : fifo_mem[rd_ptr];

`ifdef URV_DBG_MBX_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_hit;
   logic             err_flag;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wait_cnt <= '0;
         err_flag <= 1'b0;
      end else begin
         // Cleared during SEND so the first WAIT cycle sees zero
         if (state == SEND) begin
            wait_cnt <= '0;
         end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (timeout_hit) begin
            err_flag <= 1'b1;
         end else if (h_err_clr_i) begin
            err_flag <= 1'b0;
         end
      end
   end

   assign h_err_timeout_o = err_flag;
`else
   logic unused_err_clr;
   assign unused_err_clr  = h_err_clr_i;
   assign h_err_timeout_o = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
`ifdef URV_DBG_MBX_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = SEND;
            end
         end
         SEND: begin
            state_nx = WAIT;
         end
         WAIT: begin
            // A capture on the final cycle counts as the response, not a timeout
            if (push) begin
               state_nx = IDLE;
            end
`ifdef URV_DBG_MBX_TIMEOUT_EN
            else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_nx    = IDLE;
               timeout_hit = 1'b1;
            end
`endif
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mbxi_data <= 32'h0;
         holdoff   <= 1'b1;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
      end else begin
         holdoff <= push;
         if (accept) begin
            mbxi_data <= h_wr_data_i;
         end
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; occupancy alone decides what is visible
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr] <= dbg_mbxo_data_i;
      end
   end

endmodule

// File: tb/tb_urv_dbg_mbx_host.sv
// tb/tb_urv_dbg_mbx_host.sv - randomized self-checking bench for urv_dbg_mbx_host
module tb_urv_dbg_mbx_host;

   localparam int TO    = 8;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] h_wr_data;
   logic        h_wr_valid;
   logic        h_wr_ready;
   logic [31:0] h_rd_data;
   logic        h_rd_valid;
   logic        h_rd_ready;
   logic        h_busy;
   logic        h_err;
   logic        h_err_clr;
   logic [31:0] mbxi_data;
   logic        mbxi_valid;
   logic [31:0] mbxo_data;
   logic        mbxo_valid;
   logic        mbxo_read;

   always #5 clk = ~clk;

   urv_dbg_mbx_host #(
      .TIMEOUT_CYCLES (TO),
      .RD_FIFO_LOG2   (2)
   ) dut (
      .clk_i            (clk),
      .rst_n_i          (rst_n),
      .h_wr_data_i      (h_wr_data),
      .h_wr_valid_i     (h_wr_valid),
      .h_wr_ready_o     (h_wr_ready),
      .h_rd_data_o      (h_rd_data),
      .h_rd_valid_o     (h_rd_valid),
      .h_rd_ready_i     (h_rd_ready),
      .h_busy_o         (h_busy),
      .h_err_timeout_o  (h_err),
      .h_err_clr_i      (h_err_clr),
      .dbg_mbxi_data_o  (mbxi_data),
      .dbg_mbxi_valid_o (mbxi_valid),
      .dbg_mbxo_data_i  (mbxo_data),
      .dbg_mbxo_valid_i (mbxo_valid),
      .dbg_mbxo_read_o  (mbxo_read)
   );

   int tests = 0;
   int errors = 0;

   // reference model: FIFO as a queue, transaction phase 0 idle / 1 send / 2 wait
   logic [31:0] m_q[$];
   int          m_phase;
   int          m_wcnt;
   bit          m_prev_rd;
   logic [31:0] m_mbxi;
   bit          m_err;

   // core emulation and counters
   logic [31:0] core_src[$];
   bit          rd_seen;
   bit          core_hold;
   bit          last_acc;
   int          n_rd;
   int          n_wi;
   int          n_pop;
   int          cyc;
   int          last_rd_cyc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_phase     = 0;
      m_wcnt      = 0;
      m_prev_rd   = 1'b1;
      m_mbxi      = 32'h0;
      m_err       = 1'b0;
      core_src.delete();
      rd_seen     = 1'b0;
      core_hold   = 1'b0;
      last_acc    = 1'b0;
      n_rd        = 0;
      n_wi        = 0;
      n_pop       = 0;
      last_rd_cyc = -10;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      h_wr_valid = 1'b0;
      h_wr_data  = 32'h0;
      h_rd_ready = 1'b0;
      h_err_clr  = 1'b0;
      mbxo_valid = 1'b0;
      mbxo_data  = 32'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
   endtask

   // One clock: check outputs mid-cycle against the model, then advance the model
   task automatic step();
      int          occ;
      int          nphase;
      bit          pop;
      bit          exp_rd;
      bit          acc;
      bit          set_err;
      logic [31:0] head;
      @(negedge clk);
      cyc++;
      occ    = m_q.size();
      head   = (occ != 0) ? m_q[0] : 32'h0;
      pop    = (occ != 0) && h_rd_ready;
      exp_rd = mbxo_valid && !m_prev_rd && ((occ < DEPTH) || pop);
      acc    = h_wr_valid && (m_phase == 0);
      check("wr_ready",   32'(h_wr_ready), 32'(m_phase == 0));
      check("busy",       32'(h_busy),     32'(m_phase != 0));
      check("mbxi_valid", 32'(mbxi_valid), 32'(m_phase == 1));
      check("mbxi_data",  mbxi_data,       m_mbxi);
      check("rd_valid",   32'(h_rd_valid), 32'(occ != 0));
      check("rd_data",    h_rd_data,       head);
      check("mbxo_read",  32'(mbxo_read),  32'(exp_rd));
      check("err",        32'(h_err),      32'(m_err));
      if (mbxo_read) begin
         check("rd_gap_ge2", 32'((cyc - last_rd_cyc) >= 2), 32'd1);
         last_rd_cyc = cyc;
         n_rd++;
         rd_seen = 1'b1;
      end
      if (mbxi_valid) n_wi++;
      if (pop) begin
         void'(m_q.pop_front());
         n_pop++;
      end
      if (exp_rd) m_q.push_back(mbxo_data);
      set_err = 1'b0;
      nphase  = m_phase;
      case (m_phase)
         0: begin
            if (acc) begin
               nphase = 1;
               m_mbxi = h_wr_data;
            end
         end
         1: begin
            nphase = 2;
            m_wcnt = 0;
         end
         default: begin
            if (exp_rd) nphase = 0;
`ifdef URV_DBG_MBX_TIMEOUT_EN
            else if (m_wcnt == TO - 1) begin
               nphase  = 0;
               set_err = 1'b1;
            end else m_wcnt++;
`endif
         end
      endcase
      if (set_err) m_err = 1'b1;
      else if (h_err_clr) m_err = 1'b0;
      m_prev_rd = exp_rd;
      m_phase   = nphase;
      last_acc  = acc;
      @(posedge clk);
      #1;
   endtask

   // Core side: valid stays high one extra cycle after a strobe (registered clear)
   task automatic core_drive();
      if (rd_seen) begin
         rd_seen   = 1'b0;
         core_hold = 1'b1;
      end else begin
         if (core_hold) begin
            core_hold  = 1'b0;
            mbxo_valid = 1'b0;
         end
         if (!mbxo_valid && core_src.size() != 0) begin
            mbxo_valid = 1'b1;
            mbxo_data  = core_src.pop_front();
         end
      end
   endtask

   task automatic host_random();
      if (last_acc) h_wr_valid = 1'b0;
      if (!h_wr_valid && ($urandom % 6 == 0)) begin
         h_wr_valid = 1'b1;
         h_wr_data  = $urandom;
      end
      h_rd_ready = ($urandom % 3 != 0);
      h_err_clr  = ($urandom % 10 == 0);
      if (core_src.size() < 3 && ($urandom % 4 == 0)) core_src.push_back($urandom);
   endtask

   initial begin
      cyc = 0;
      do_reset();

      // reset state
      check("rst_wr_ready",  32'(h_wr_ready), 32'd1);
      check("rst_busy",      32'(h_busy),     32'd0);
      check("rst_rd_valid",  32'(h_rd_valid), 32'd0);
      check("rst_mbxi_data", mbxi_data,       32'h0);
      check("rst_err",       32'(h_err),      32'd0);
      step();

      // single transaction: response arrives 3 cycles after the inbound strobe
      h_wr_data  = 32'hDEADBEEF;
      h_wr_valid = 1'b1;
      step();
      h_wr_valid = 1'b0;
      repeat (3) begin
         core_drive();
         step();
      end
      core_src.push_back(32'h12345678);
      repeat (2) begin
         core_drive();
         step();
      end
      check("t26_mbxi_strobes", 32'(n_wi),       32'd1);
      check("t26_read_strobes", 32'(n_rd),       32'd1);
      check("t26_head",         h_rd_data,       32'h12345678);
      check("t26_mbxi_data",    mbxi_data,       32'hDEADBEEF);
      check("t26_idle",         32'(h_busy),     32'd0);

      // unsolicited words in IDLE with the host never popping
      do_reset();
      for (int i = 0; i < 5; i++) core_src.push_back(32'hA000_0000 + 32'(i));
      repeat (16) begin
         core_drive();
         step();
      end
      #1;
      check("t27_read_strobes", 32'(n_rd),      32'd4);
      check("t27_pending_low",  32'(mbxo_read), 32'd0);
      check("t27_head",         h_rd_data,      32'hA000_0000);
      h_rd_ready = 1'b1;
      core_drive();
      step();
      h_rd_ready = 1'b0;
      repeat (4) begin
         core_drive();
         step();
      end
      check("t27_fifth_taken",  32'(n_rd), 32'd5);
      check("t27_head_after",   h_rd_data, 32'hA000_0001);

      // FIFO full, host pops every cycle, core streams fresh words
      for (int i = 0; i < 10; i++) core_src.push_back(32'hB000_0000 + 32'(i));
      h_rd_ready = 1'b1;
      repeat (40) begin
         core_drive();
         step();
      end
      h_rd_ready = 1'b0;
      check("t28_read_strobes", 32'(n_rd),       32'd15);
      check("t28_pops",         32'(n_pop),      32'd15);
      check("t28_drained",      32'(h_rd_valid), 32'd0);

      // asynchronous reset during WAIT with two words queued
      do_reset();
      core_src.push_back(32'hC000_0001);
      core_src.push_back(32'hC000_0002);
      repeat (6) begin
         core_drive();
         step();
      end
      h_wr_data  = 32'h5555_AAAA;
      h_wr_valid = 1'b1;
      step();
      h_wr_valid = 1'b0;
      repeat (2) step();
      check("t30_busy_before", 32'(h_busy),     32'd1);
      check("t30_occ_before",  32'(h_rd_valid), 32'd1);
      mbxo_valid = 1'b1;
      mbxo_data  = 32'hC000_0003;
      #1 rst_n = 1'b0;
      #1;
      check("t30_async_busy",      32'(h_busy),      32'd0);
      check("t30_async_wr_ready",  32'(h_wr_ready),  32'd0);
      check("t30_async_rd_valid",  32'(h_rd_valid),  32'd0);
      check("t30_async_rd_data",   h_rd_data,        32'h0);
      check("t30_async_mbxi_v",    32'(mbxi_valid),  32'd0);
      check("t30_async_mbxi_data", mbxi_data,        32'h0);
      check("t30_async_read",      32'(mbxo_read),   32'd0);
      check("t30_async_err",       32'(h_err),       32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      check("t30_release_read", 32'(mbxo_read), 32'd0);
      step();
      repeat (4) begin
         core_drive();
         step();
      end
      check("t30_post_capture", 32'(n_rd), 32'd1);
      check("t30_post_head",    h_rd_data, 32'hC000_0003);

      // silent core: timeout abort when enabled, indefinite WAIT otherwise
      do_reset();
      h_wr_data  = 32'h0BAD_F00D;
      h_wr_valid = 1'b1;
      step();
      h_wr_valid = 1'b0;
      repeat (1 + TO) step();
`ifdef URV_DBG_MBX_TIMEOUT_EN
      check("to_idle", 32'(h_busy), 32'd0);
      check("to_err",  32'(h_err),  32'd1);
`else
      check("to_still_wait", 32'(h_busy), 32'd1);
      check("to_err_tied",   32'(h_err),  32'd0);
`endif
      h_err_clr = 1'b1;
      step();
      h_err_clr = 1'b0;
      check("to_err_cleared", 32'(h_err), 32'd0);
`ifndef URV_DBG_MBX_TIMEOUT_EN
      core_src.push_back(32'hD000_0000);
      repeat (3) begin
         core_drive();
         step();
      end
      check("to_resp_idle", 32'(h_busy), 32'd0);
`endif
      // response lands in the last allowed WAIT cycle: no error
      h_rd_ready = 1'b1;
      step();
      h_rd_ready = 1'b0;
      h_wr_valid = 1'b1;
      step();
      h_wr_valid = 1'b0;
      repeat (1 + TO - 1) begin
         core_drive();
         step();
      end
      core_src.push_back(32'hE000_0008);
      core_drive();
      step();
      check("to_edge_no_err", 32'(h_err),  32'd0);
      check("to_edge_idle",   32'(h_busy), 32'd0);
      check("to_edge_head",   h_rd_data,   32'hE000_0008);

      // randomized traffic against the model
      do_reset();
      repeat (1500) begin
         host_random();
         core_drive();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
